nonce_gen: RTL and testbench

- Upstream stage of concatenador. Drives the nonce[31:0] that concatenador packs with entrada[95:0] into bloque_in[127:0].
- Sequences nonce trials and waits for the hash core's result on each trial.
- Compares each returned hash against a target. Reports the winning nonce, or reports exhaustion when the search range runs out.

---
 rtl/nonce_gen_pkg.sv | 16 +
 rtl/nonce_gen_wait_timer.sv | 29 ++
 rtl/nonce_gen.sv | 143 ++++++++++++++
 tb/tb_nonce_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_gen_pkg.sv
// Shared definitions for the nonce search path (nonce_gen, concatenador, hash core).
package nonce_pkg;

  localparam int NONCE_W_DEF = 32;
  localparam int HASH_W_DEF  = 24;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT      = 3'd2,
    ST_FOUND     = 3'd3,
    ST_EXHAUSTED = 3'd4,
    ST_ERROR     = 3'd5
  } state_t;

endpackage

// File: rtl/nonce_gen_wait_timer.sv
// Bounded wait counter: cleared per trial, o_expire flags the last allowed wait cycle.
module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_L,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;

  // Expire on the TIMEOUT-th enabled cycle after a clear; the count saturates there.
  assign o_expire = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nonce_gen.sv
// Nonce search sequencer: issues trial nonces, waits for the hash core, and
// reports a hit, range exhaustion or a hash-core timeout.
module nonce_gen
  import nonce_pkg::*;
#(
  parameter int NONCE_W   = NONCE_W_DEF,
  parameter int HASH_W    = HASH_W_DEF,
  parameter int MAX_TRIES = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [HASH_W-1:0]  target,
  input  logic               hash_valid,
  input  logic [HASH_W-1:0]  hash,
  output logic [NONCE_W-1:0] nonce,
  output logic               nonce_valid,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic               timeout_err,
  output logic [NONCE_W-1:0] nonce_found,
  output logic [31:0]        attempts
);

  localparam logic [31:0] LP_MAX_TRIES = 32'(MAX_TRIES);

  state_t             r_state;
  logic [NONCE_W-1:0] r_nonce;
  logic [NONCE_W-1:0] r_nonce_found;
  logic [HASH_W-1:0]  r_target;
  logic [31:0]        r_attempts;
  logic               r_nonce_valid;
  logic               r_busy;
  logic               r_found;
  logic               r_exhausted;
  logic               r_timeout_err;

  logic               w_timer_clr;
  logic               w_timer_en;
  logic               w_expire;
  logic [31:0]        w_attempts_nxt;
  logic               w_hit;
  logic               w_range_end;

  assign w_timer_clr    = (r_state == ST_ISSUE);
  assign w_timer_en     = (r_state == ST_WAIT);
  assign w_attempts_nxt = r_attempts + 32'd1;
  assign w_hit          = (hash < r_target);
  // The search never wraps past all-ones; a nonzero MAX_TRIES can end it earlier.
  assign w_range_end    = (r_nonce == '1) ||
                          ((MAX_TRIES != 0) && (w_attempts_nxt == LP_MAX_TRIES));

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset_L  (reset_L),
    .i_clr    (w_timer_clr),
    .i_en     (w_timer_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state       <= ST_IDLE;
      r_nonce       <= '0;
      r_nonce_found <= '0;
      r_target      <= '0;
      r_attempts    <= '0;
      r_nonce_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_found       <= 1'b0;
      r_exhausted   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_nonce_valid <= 1'b0;
      case (r_state)
        ST_ISSUE: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        // abort outranks a same-cycle hash result so no flag is raised.
        ST_WAIT: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (hash_valid) begin
            r_attempts <= w_attempts_nxt;
            if (w_hit) begin
              r_nonce_found <= r_nonce;
              r_found       <= 1'b1;
              r_state       <= ST_FOUND;
              r_busy        <= 1'b0;
            end else if (w_range_end) begin
              r_exhausted <= 1'b1;
              r_state     <= ST_EXHAUSTED;
              r_busy      <= 1'b0;
            end else begin
              r_nonce       <= r_nonce + 1'b1;
              r_state       <= ST_ISSUE;
              r_nonce_valid <= 1'b1;
            end
          end else if (w_expire) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_ERROR;
            r_busy        <= 1'b0;
          end
        end
        default: begin
          if (start) begin
            r_nonce       <= nonce_base;
            r_target      <= target;
            r_attempts    <= '0;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_nonce_valid <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ST_ISSUE;
          end
        end
      endcase
    end
  end

  assign nonce       = r_nonce;
  assign nonce_valid = r_nonce_valid;
  assign busy        = r_busy;
  assign found       = r_found;
  assign exhausted   = r_exhausted;
  assign timeout_err = r_timeout_err;
  assign nonce_found = r_nonce_found;
  assign attempts    = r_attempts;

endmodule

// File: tb/tb_nonce_gen.sv
// Scoreboard bench for nonce_gen: expected nonces and end-of-search results are queued
// by the stimulus and checked by a monitor when the DUT presents them.
module tb_nonce_gen;

  typedef struct {
    logic [31:0] nonce;
    logic [31:0] nf;
    logic [31:0] att;
    logic        found;
    logic        exh;
    logic        to;
    logic        nv;
  } res_t;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic        start = 1'b0;
  logic        abort_m = 1'b0;
  logic        abort_r = 1'b0;
  wire         abort = abort_m | abort_r;
  logic [31:0] nonce_base = '0;
  logic [23:0] target = '0;
  logic        hash_valid = 1'b0;
  logic [23:0] hash = '0;
  logic [31:0] nonce, nonce_found, attempts;
  logic        nonce_valid, busy, found, exhausted, timeout_err;

  logic        start3 = 1'b0;
  logic        abort3 = 1'b0;
  logic        hash_valid3 = 1'b0;
  logic [23:0] hash3 = '0;
  logic [31:0] nonce3, nonce_found3, attempts3;
  logic        nonce_valid3, busy3, found3, exhausted3, timeout_err3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_nonce_q[$];
  res_t        exp_res_q[$];

  logic        resp_en = 1'b0;
  logic        abort_on_hit = 1'b0;
  logic [31:0] hit_nonce = '0;
  logic [23:0] hit_hash = 24'h0007FF;
  logic        pend = 1'b0, pend_abort = 1'b0, pend3 = 1'b0;
  logic [23:0] pend_hash = '0;
  logic        prev_busy = 1'b0;

  always #5 clk = ~clk;

  nonce_gen #(.NONCE_W(32), .HASH_W(24), .MAX_TRIES(0), .TIMEOUT(16)) dut (
    .clk(clk), .reset_L(reset_L), .start(start), .abort(abort),
    .nonce_base(nonce_base), .target(target), .hash_valid(hash_valid), .hash(hash),
    .nonce(nonce), .nonce_valid(nonce_valid), .busy(busy), .found(found),
    .exhausted(exhausted), .timeout_err(timeout_err), .nonce_found(nonce_found),
    .attempts(attempts)
  );

  nonce_gen #(.NONCE_W(32), .HASH_W(24), .MAX_TRIES(3), .TIMEOUT(16)) dut3 (
    .clk(clk), .reset_L(reset_L), .start(start3), .abort(abort3),
    .nonce_base(nonce_base), .target(target), .hash_valid(hash_valid3), .hash(hash3),
    .nonce(nonce3), .nonce_valid(nonce_valid3), .busy(busy3), .found(found3),
    .exhausted(exhausted3), .timeout_err(timeout_err3), .nonce_found(nonce_found3),
    .attempts(attempts3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Hash core model: answers one cycle after nonce_valid, i.e. in the first WAIT cycle.
  always @(negedge clk) begin
    hash_valid = pend;
    hash       = pend_hash;
    abort_r    = pend && pend_abort;
    pend       = resp_en && nonce_valid;
    pend_hash  = (nonce == hit_nonce) ? hit_hash : 24'hFFFFFF;
    pend_abort = abort_on_hit && (nonce == hit_nonce);
    hash_valid3 = pend3;
    hash3       = 24'h000000;
    pend3       = nonce_valid3;
  end

  // Monitor: every nonce_valid and every end of search is matched against the queues.
  always @(negedge clk) begin
    if (nonce_valid === 1'b1) begin
      if (exp_nonce_q.size() == 0) begin
        check("unexpected_nonce_valid", nonce, 32'hDEADBEEF);
      end else begin
        check("nonce_seq", nonce, exp_nonce_q.pop_front());
      end
    end
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      if (exp_res_q.size() == 0) begin
        check("unexpected_search_end", attempts, 32'hDEADBEEF);
      end else begin
        res_t r;
        r = exp_res_q.pop_front();
        check("res_nonce", nonce, r.nonce);
        check("res_nonce_found", nonce_found, r.nf);
        check("res_attempts", attempts, r.att);
        check("res_found", {31'd0, found}, {31'd0, r.found});
        check("res_exhausted", {31'd0, exhausted}, {31'd0, r.exh});
        check("res_timeout_err", {31'd0, timeout_err}, {31'd0, r.to});
        check("res_nonce_valid", {31'd0, nonce_valid}, {31'd0, r.nv});
      end
    end
    prev_busy = busy;
  end

  task automatic push_res(input logic [31:0] n, input logic [31:0] nf, input logic [31:0] att,
                          input logic f, input logic e, input logic t);
    res_t r;
    r.nonce = n; r.nf = nf; r.att = att; r.found = f; r.exh = e; r.to = t; r.nv = 1'b0;
    exp_res_q.push_back(r);
  endtask

  task automatic do_start(input logic [31:0] b, input logic [23:0] t);
    @(negedge clk);
    nonce_base = b;
    target     = t;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit, input int exp_cycles);
    int cyc;
    cyc = 0;
    while (busy && cyc < limit) begin
      cyc++;
      @(negedge clk);
    end
    check(name, cyc, exp_cycles);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    check("rst_nonce", nonce, 32'h0);
    check("rst_nonce_found", nonce_found, 32'h0);
    check("rst_attempts", attempts, 32'h0);
    check("rst_flags", {27'd0, nonce_valid, busy, found, exhausted, timeout_err}, 32'h0);
    reset_L = 1'b1;

    // Reset in the middle of a trial.
    resp_en = 1'b0;
    exp_nonce_q.push_back(32'h10);
    push_res(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    do_start(32'h10, 24'h000800);
    repeat (2) @(negedge clk);
    reset_L = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    @(negedge clk);

    // Three misses then a hit; back-to-back 2-cycle trials.
    resp_en = 1'b1; hit_nonce = 32'h103; hit_hash = 24'h0007FF;
    for (int i = 0; i < 4; i++) exp_nonce_q.push_back(32'h100 + i);
    push_res(32'h103, 32'h103, 32'd4, 1'b1, 1'b0, 1'b0);
    do_start(32'h100, 24'h000800);
    wait_idle("hit_busy_cycles", 40, 8);

    // Range end at all-ones, no wrap.
    hit_nonce = 32'h0;
    exp_nonce_q.push_back(32'hFFFFFFFE);
    exp_nonce_q.push_back(32'hFFFFFFFF);
    push_res(32'hFFFFFFFF, 32'h103, 32'd2, 1'b0, 1'b1, 1'b0);
    do_start(32'hFFFFFFFE, 24'h000800);
    wait_idle("exh_busy_cycles", 40, 4);
    repeat (3) @(negedge clk);
    check("exh_nonce_hold", nonce, 32'hFFFFFFFF);
    check("exh_flag_hold", {31'd0, exhausted}, 32'd1);

    // Hash core never answers: ISSUE plus 16 WAIT cycles, then ERROR.
    resp_en = 1'b0;
    exp_nonce_q.push_back(32'h20);
    push_res(32'h20, 32'h103, 32'd0, 1'b0, 1'b0, 1'b1);
    do_start(32'h20, 24'h000800);
    wait_idle("timeout_busy_cycles", 60, 17);

    // Restart from ERROR clears timeout_err.
    resp_en = 1'b1; hit_nonce = 32'h30;
    exp_nonce_q.push_back(32'h30);
    push_res(32'h30, 32'h30, 32'd1, 1'b1, 1'b0, 1'b0);
    do_start(32'h30, 24'h000800);
    wait_idle("restart_busy_cycles", 40, 2);

    // abort coincides with the hit result: abort wins, no flag.
    hit_nonce = 32'h41; abort_on_hit = 1'b1;
    exp_nonce_q.push_back(32'h40);
    exp_nonce_q.push_back(32'h41);
    push_res(32'h41, 32'h30, 32'd1, 1'b0, 1'b0, 1'b0);
    do_start(32'h40, 24'h000800);
    wait_idle("abort_busy_cycles", 40, 4);
    abort_on_hit = 1'b0;

    // start while busy is ignored.
    resp_en = 1'b0;
    exp_nonce_q.push_back(32'h60);
    push_res(32'h60, 32'h30, 32'd0, 1'b0, 1'b0, 1'b0);
    do_start(32'h60, 24'h000800);
    repeat (2) @(negedge clk);
    do_start(32'h99, 24'h000800);
    repeat (2) @(negedge clk);
    check("busy_start_ignored", nonce, 32'h60);
    abort_m = 1'b1;
    @(negedge clk);
    abort_m = 1'b0;
    @(negedge clk);

    // MAX_TRIES=3 instance with target=0: hash 0 is still a miss.
    @(negedge clk);
    nonce_base = 32'h50; target = 24'h000000; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc = 0;
    while (busy3 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    check("max_busy_cycles", cyc, 6);
    check("max_exhausted", {31'd0, exhausted3}, 32'd1);
    check("max_found", {31'd0, found3}, 32'd0);
    check("max_attempts", attempts3, 32'd3);
    check("max_nonce", nonce3, 32'h52);

    repeat (2) @(negedge clk);
    check("nonce_queue_empty", exp_nonce_q.size(), 32'd0);
    check("result_queue_empty", exp_res_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
